// File: rtl/uart_pkg.sv
// Shared UART definitions: data width, default RX FIFO depth
// and the baud-rate select encodings used by the baud generator.
package uart_pkg;

    localparam int UART_DATA_W = 8;
    localparam int FIFO_DEPTH  = 16;

    typedef enum logic [1:0] {
        BAUD_9600   = 2'd0,
        BAUD_19200  = 2'd1,
        BAUD_57600  = 2'd2,
        BAUD_115200 = 2'd3
    } baud_sel_e;

endpackage

// File: rtl/uart_sync_edge.sv
// Two-flop synchroniser plus rising-edge detector for a slow
// strobe arriving from another clock domain.
module uart_sync_edge (
    input  logic clk,
    input  logic reset_n,
    input  logic d_i,
    output logic rise_o
);

    logic s1_q;
    logic s2_q;
    logic s3_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign rise_o = s2_q & ~s3_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO fed by the UART receiver strobe and drained
// by host reads; tracks occupancy and a sticky overflow flag.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH  = FIFO_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   rx_valid,
    input  logic [UART_DATA_W-1:0] rx_data,
    input  logic                   rd_en,
    input  logic                   ovf_clr,
    output logic [UART_DATA_W-1:0] rd_data,
    output logic                   rd_valid,
    output logic                   empty,
    output logic                   full,
    output logic [ADDR_W:0]        count,
    output logic                   overflow
);

    logic [UART_DATA_W-1:0] mem_q [DEPTH];

    logic [ADDR_W-1:0]      wr_ptr_q;
    logic [ADDR_W-1:0]      rd_ptr_q;
    logic [ADDR_W:0]        count_q;
    logic [ADDR_W:0]        count_d;
    logic [UART_DATA_W-1:0] rd_data_q;
    logic                   rd_valid_q;
    logic                   ovf_q;

    logic wr_req;
    logic rd_acc;
    logic wr_acc;
    logic drop;

    uart_sync_edge u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d_i     (rx_valid),
        .rise_o  (wr_req)
    );

    assign empty  = (count_q == '0);
    assign full   = (count_q == (ADDR_W+1)'(DEPTH));
    assign rd_acc = rd_en & ~empty;
    assign wr_acc = wr_req & (~full | rd_acc);
    assign drop   = wr_req & full & ~rd_acc;

    always_comb begin
        count_d = count_q;
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // rx_data has been stable for two clk cycles by the time wr_req fires
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q] <= rx_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            count_q    <= count_d;
            rd_valid_q <= rd_acc;
            if (wr_acc) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr_q  <= rd_ptr_q + 1'b1;
                rd_data_q <= mem_q[rd_ptr_q];
            end
            if (drop) begin
                ovf_q <= 1'b1;
            end else if (ovf_clr) begin
                ovf_q <= 1'b0;
            end
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign count    = count_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed testbench for uart_rx_fifo: reset, capture, ordering,
// wrap, overflow and simultaneous read/write cases.
module tb_uart_rx_fifo;

    logic       clk;
    logic       reset_n;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rd_en;
    logic       ovf_clr;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       empty;
    logic       full;
    logic [4:0] count;
    logic       overflow;

    int pass_cnt;
    int total_cnt;

    uart_rx_fifo #(.DEPTH(16), .ADDR_W(4)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .rd_en    (rd_en),
        .ovf_clr  (ovf_clr),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .empty    (empty),
        .full     (full),
        .count    (count),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        repeat (4) @(negedge clk);
        rx_valid = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic rd_pulse();
        @(negedge clk);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        total_cnt++;
        if (count !== 5'd0 || empty !== 1'b1 || full !== 1'b0 ||
            overflow !== 1'b0 || rd_valid !== 1'b0 || rd_data !== 8'h00) begin
            $display("FAIL reset_state: cnt=%0d emp=%b full=%b ovf=%b rv=%b rd=%h exp 0 1 0 0 0 00",
                     count, empty, full, overflow, rd_valid, rd_data);
        end else pass_cnt++;
        for (int i = 0; i < 5; i++) send_byte(8'(8'hC0 + i));
        total_cnt++;
        if (count !== 5'd5) $display("FAIL reset_load: count=%0d exp 5", count);
        else pass_cnt++;
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        total_cnt++;
        if (count !== 5'd0 || empty !== 1'b1 || overflow !== 1'b0 || rd_valid !== 1'b0) begin
            $display("FAIL reset_mid: cnt=%0d emp=%b ovf=%b rv=%b exp 0 1 0 0",
                     count, empty, overflow, rd_valid);
        end else pass_cnt++;
        rd_pulse();
        total_cnt++;
        if (rd_valid !== 1'b0) $display("FAIL reset_rd: rd_valid=%b exp 0", rd_valid);
        else pass_cnt++;
    endtask

    task automatic test_single();
        bit seen;
        seen = 1'b0;
        @(negedge clk);
        rx_data  = 8'hA5;
        rx_valid = 1'b1;
        for (int i = 0; i < 4 && !seen; i++) begin
            @(negedge clk);
            if (count == 5'd1) seen = 1'b1;
        end
        total_cnt++;
        if (!seen) $display("FAIL single_latency: count=%0d exp 1 within 4 cycles", count);
        else pass_cnt++;
        repeat (200) @(negedge clk);
        total_cnt++;
        if (count !== 5'd1) $display("FAIL single_once: count=%0d exp 1", count);
        else pass_cnt++;
        rx_valid = 1'b0;
        repeat (4) @(negedge clk);
        rd_pulse();
        total_cnt++;
        if (rd_valid !== 1'b1 || rd_data !== 8'hA5) begin
            $display("FAIL single_read: rv=%b rd=%h exp 1 a5", rd_valid, rd_data);
        end else pass_cnt++;
        total_cnt++;
        if (empty !== 1'b1) $display("FAIL single_empty: empty=%b exp 1", empty);
        else pass_cnt++;
    endtask

    task automatic test_fill_wrap();
        for (int i = 0; i < 16; i++) send_byte(8'(i));
        total_cnt++;
        if (full !== 1'b1 || count !== 5'd16) begin
            $display("FAIL fill_full: full=%b count=%0d exp 1 16", full, count);
        end else pass_cnt++;
        for (int i = 0; i < 8; i++) begin
            rd_pulse();
            total_cnt++;
            if (rd_valid !== 1'b1 || rd_data !== 8'(i)) begin
                $display("FAIL fill_rd%0d: rv=%b rd=%h exp 1 %h", i, rd_valid, rd_data, 8'(i));
            end else pass_cnt++;
        end
        for (int i = 0; i < 8; i++) send_byte(8'(8'h10 + i));
        for (int i = 0; i < 16; i++) begin
            rd_pulse();
            total_cnt++;
            if (rd_valid !== 1'b1 || rd_data !== 8'(8'h08 + i)) begin
                $display("FAIL wrap_rd%0d: rv=%b rd=%h exp 1 %h", i, rd_valid, rd_data, 8'(8'h08 + i));
            end else pass_cnt++;
        end
        total_cnt++;
        if (empty !== 1'b1 || count !== 5'd0) begin
            $display("FAIL wrap_empty: empty=%b count=%0d exp 1 0", empty, count);
        end else pass_cnt++;
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 16; i++) send_byte(8'(8'h20 + i));
        send_byte(8'hEE);
        total_cnt++;
        if (overflow !== 1'b1 || count !== 5'd16) begin
            $display("FAIL ovf_set: ovf=%b count=%0d exp 1 16", overflow, count);
        end else pass_cnt++;
        for (int i = 0; i < 16; i++) begin
            rd_pulse();
            total_cnt++;
            if (rd_valid !== 1'b1 || rd_data !== 8'(8'h20 + i)) begin
                $display("FAIL ovf_rd%0d: rv=%b rd=%h exp 1 %h", i, rd_valid, rd_data, 8'(8'h20 + i));
            end else pass_cnt++;
        end
        total_cnt++;
        if (overflow !== 1'b1 || empty !== 1'b1) begin
            $display("FAIL ovf_sticky: ovf=%b empty=%b exp 1 1", overflow, empty);
        end else pass_cnt++;
        @(negedge clk);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        total_cnt++;
        if (overflow !== 1'b0) $display("FAIL ovf_clr: ovf=%b exp 0", overflow);
        else pass_cnt++;
    endtask

    task automatic test_sim_full();
        for (int i = 0; i < 16; i++) send_byte(8'(8'h30 + i));
        @(negedge clk);
        rx_data  = 8'h55;
        rx_valid = 1'b1;
        repeat (2) @(negedge clk);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        total_cnt++;
        if (rd_valid !== 1'b1 || rd_data !== 8'h30 || count !== 5'd16 || overflow !== 1'b0) begin
            $display("FAIL simfull: rv=%b rd=%h cnt=%0d ovf=%b exp 1 30 16 0",
                     rd_valid, rd_data, count, overflow);
        end else pass_cnt++;
        repeat (2) @(negedge clk);
        rx_valid = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            logic [7:0] exp_b;
            exp_b = (i == 15) ? 8'h55 : 8'(8'h31 + i);
            rd_pulse();
            total_cnt++;
            if (rd_valid !== 1'b1 || rd_data !== exp_b) begin
                $display("FAIL simfull_rd%0d: rv=%b rd=%h exp 1 %h", i, rd_valid, rd_data, exp_b);
            end else pass_cnt++;
        end
        total_cnt++;
        if (empty !== 1'b1 || overflow !== 1'b0) begin
            $display("FAIL simfull_end: empty=%b ovf=%b exp 1 0", empty, overflow);
        end else pass_cnt++;
    endtask

    task automatic test_read_empty();
        int bad;
        bad = 0;
        @(negedge clk);
        rd_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rd_valid !== 1'b0 || rd_data !== 8'h55 || count !== 5'd0) bad++;
        end
        total_cnt++;
        if (bad != 0) begin
            $display("FAIL rdempty_hold: %0d bad cycles rv=%b rd=%h cnt=%0d exp 0 55 0",
                     bad, rd_valid, rd_data, count);
        end else pass_cnt++;
        rx_data  = 8'h77;
        rx_valid = 1'b1;
        repeat (3) @(negedge clk);
        total_cnt++;
        if (count !== 5'd1 || rd_valid !== 1'b0) begin
            $display("FAIL rdempty_wr: cnt=%0d rv=%b exp 1 0", count, rd_valid);
        end else pass_cnt++;
        @(negedge clk);
        rd_en = 1'b0;
        total_cnt++;
        if (rd_valid !== 1'b1 || rd_data !== 8'h77 || count !== 5'd0) begin
            $display("FAIL rdempty_rd: rv=%b rd=%h cnt=%0d exp 1 77 0", rd_valid, rd_data, count);
        end else pass_cnt++;
        rx_valid = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        reset_n   = 1'b0;
        rx_valid  = 1'b0;
        rx_data   = 8'h00;
        rd_en     = 1'b0;
        ovf_clr   = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_single();
        test_fill_wrap();
        test_overflow();
        test_sim_full();
        test_read_empty();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
